// File: rtl/exu_wb_arbiter.sv
// Writeback arbiter: per-unit result queues drained round-robin
// onto one registered register-file write port.
module exu_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int NREQ  = 4,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*5-1:0]         req_rd_addr,
  input  logic [NREQ*XLEN-1:0]      req_data,
  input  logic [NREQ*XLEN-1:0]      req_tag,
  input  logic                      wb_stall,
  output logic                      wb_rd_wr_en,
  output logic [4:0]                wb_rd_addr,
  output logic [XLEN-1:0]           wb_data,
  output logic [XLEN-1:0]           wb_tag,
  output logic [$clog2(NREQ)-1:0]   wb_src,
  output logic [31:0]               wb_pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(NREQ);

  logic [CW-1:0]   cnt_q  [NREQ];
  logic [CW-1:0]   cnt_d  [NREQ];
  logic [PW-1:0]   rptr_q [NREQ];
  logic [PW-1:0]   rptr_d [NREQ];
  logic [PW-1:0]   wptr_q [NREQ];
  logic [PW-1:0]   wptr_d [NREQ];
  logic [4:0]      rd_q   [NREQ][DEPTH];
  logic [4:0]      rd_d   [NREQ][DEPTH];
  logic [XLEN-1:0] dat_q  [NREQ][DEPTH];
  logic [XLEN-1:0] dat_d  [NREQ][DEPTH];
  logic [XLEN-1:0] tg_q   [NREQ][DEPTH];
  logic [XLEN-1:0] tg_d   [NREQ][DEPTH];

  logic [SW-1:0]   rr_q, rr_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      addr_q, addr_d;
  logic [XLEN-1:0] wdat_q, wdat_d;
  logic [XLEN-1:0] wtag_q, wtag_d;
  logic [SW-1:0]   src_q, src_d;
  logic [31:0]     pend_q, pend_d;

  logic            gnt_vld;
  logic [SW-1:0]   gnt_idx;
  logic [NREQ-1:0] push;
  logic [NREQ-1:0] pop;
  logic [PW-1:0]   off;

  function automatic int wrap(input int a);
    return a % NREQ;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (cnt_q[i] < CW'(DEPTH));
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    push    = '0;
    pop     = '0;
    off     = '0;
    cnt_d   = cnt_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    rd_d    = rd_q;
    dat_d   = dat_q;
    tg_d    = tg_q;
    rr_d    = rr_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    wtag_d  = wtag_q;
    src_d   = src_q;
    pend_d  = '0;

    if (!wb_stall) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!gnt_vld && cnt_q[wrap(int'(rr_q) + k)] != '0) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(wrap(int'(rr_q) + k));
        end
      end
    end

    if (gnt_vld) begin
      wr_en_d = 1'b1;
      addr_d  = rd_q[gnt_idx][rptr_q[gnt_idx]];
      wdat_d  = dat_q[gnt_idx][rptr_q[gnt_idx]];
      wtag_d  = tg_q[gnt_idx][rptr_q[gnt_idx]];
      src_d   = gnt_idx;
      rr_d    = SW'(wrap(int'(gnt_idx) + 1));
    end

    for (int i = 0; i < NREQ; i++) begin
      // x0 writes are acknowledged but never stored
      push[i] = req_valid[i] & req_ready[i]
              & (req_rd_addr[5*i +: 5] != 5'd0);
      pop[i]  = gnt_vld && (gnt_idx == SW'(i));
      if (push[i]) begin
        rd_d[i][wptr_q[i]]  = req_rd_addr[5*i +: 5];
        dat_d[i][wptr_q[i]] = req_data[XLEN*i +: XLEN];
        tg_d[i][wptr_q[i]]  = req_tag[XLEN*i +: XLEN];
        wptr_d[i]           = wptr_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rptr_d[i] = rptr_q[i] + 1'b1;
      end
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end

    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        off = PW'(j) - rptr_d[i];
        if ({1'b0, off} < cnt_d[i]) begin
          pend_d = pend_d | (32'd1 << rd_d[i][j]);
        end
      end
    end
    if (wr_en_d) begin
      pend_d = pend_d | (32'd1 << addr_d);
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i]  <= '0;
        rptr_q[i] <= '0;
        wptr_q[i] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          rd_q[i][j]  <= '0;
          dat_q[i][j] <= '0;
          tg_q[i][j]  <= '0;
        end
      end
      rr_q    <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      wtag_q  <= '0;
      src_q   <= '0;
      pend_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      rd_q    <= rd_d;
      dat_q   <= dat_d;
      tg_q    <= tg_d;
      rr_q    <= rr_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wtag_q  <= wtag_d;
      src_q   <= src_d;
      pend_q  <= pend_d;
    end
  end

  assign wb_rd_wr_en = wr_en_q;
  assign wb_rd_addr  = addr_q;
  assign wb_data     = wdat_q;
  assign wb_tag      = wtag_q;
  assign wb_src      = src_q;
  assign wb_pending  = pend_q;

endmodule

// File: doc/exu_wb_arbiter.md
# exu_wb_arbiter

Writeback arbiter between the execution units (ALU, MUL, DIV, LSU) and the single register-file write port returning to IDU1. Each unit pushes completed results into a small private queue. A round-robin scheduler drains one entry per cycle onto a registered write port. Simultaneous completions are therefore serialized instead of colliding on an OR-merged bus, and a per-register pending mask is exported for the scoreboard.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREQ, 4, requester count; index 0=ALU, 1=MUL, 2=DIV, 3=LSU
- DEPTH, 2, entries per requester queue (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  result valid, per requester
- req_ready  out  NREQ  queue can accept, per requester
- req_rd_addr  in  NREQ*5  destination register; requester i occupies bits [5i+4:5i]
- req_data  in  NREQ*XLEN  result data; requester i occupies bits [XLEN*i+XLEN-1:XLEN*i]
- req_tag  in  NREQ*XLEN  debug instruction tag, packed the same way as req_data
- wb_stall  in  1  freeze the write port; no dequeue while high
- wb_rd_wr_en  out  1  register-file write strobe
- wb_rd_addr  out  5  write address
- wb_data  out  XLEN  write data
- wb_tag  out  XLEN  debug tag of the written entry
- wb_src  out  $clog2(NREQ)  index of the requester that produced the entry
- wb_pending  out  32  bit r set while any queued or output-registered write targets register r

## Operation
- Enqueue:
  - A request is accepted on an edge where req_valid[i] & req_ready[i] is high.
  - req_ready[i] = (count[i] < DEPTH). It depends on the registered count only and never on a same-cycle dequeue.
  - A request with rd_addr == 0 is accepted (ready honoured) but discarded. It is not stored and never produces a write.
- Queues:
  - Each queue is a FIFO holding {rd_addr, data, tag}, with a read pointer, a write pointer and a count of width $clog2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
  - Enqueue and dequeue on the same edge leave count unchanged.
- Arbitration (combinational from queue heads):
  - Register rr_ptr holds the requester with highest priority.
  - The grant goes to the first non-empty queue scanning rr_ptr, rr_ptr+1, … (mod NREQ).
  - No grant is made when wb_stall is high or all queues are empty.
- Dequeue:
  - On a grant, the head of the granted queue is popped at the edge.
  - At the same edge the output registers load {wr_en=1, addr, data, tag, src}, and rr_ptr becomes grant+1 mod NREQ.
  - With no grant, wb_rd_wr_en loads 0. The address, data, tag and src registers hold their values.
- Pending mask:
  - wb_pending is recomputed at every edge. It is the OR over all valid queue entries and the output register (when wr_en is set) of a one-hot decode of rd_addr.
  - Bit 0 is always 0.
- Ordering:
  - Entries from one requester are written in order. No ordering is guaranteed across requesters.
  - IDU1's scoreboard guarantees that no two in-flight writes target the same register.
- Reset:
  - rst high asynchronously clears all counts, pointers, rr_ptr and output registers.
  - Queued entries are lost.
  - All outputs go to 0, except req_ready, which becomes all-ones because the queues are empty.

## Timing
- Reset values: wb_rd_wr_en=0, wb_rd_addr=0, wb_data=0, wb_tag=0, wb_src=0, wb_pending=0, req_ready all 1.
- Latency:
  - A request accepted at edge E0 is at its queue head in the following cycle.
  - If granted, it is dequeued at E1. wb_rd_wr_en is high for exactly the cycle after E1.
  - Minimum latency is 2 cycles from req_valid to the write strobe.
- Throughput: one write per cycle sustained while any queue is non-empty and wb_stall=0.
- Stall timing:
  - wb_stall high in cycle N blocks the dequeue at the end of cycle N.
  - wb_rd_wr_en is low in cycle N+1.
- Back-pressure timing:
  - A full queue (count=DEPTH) drops req_ready in the same cycle the count reaches DEPTH.
  - req_ready returns one cycle after the dequeue edge.
- Pending-mask timing:
  - wb_pending[r] rises the cycle after the enqueue edge.
  - It falls the cycle after the write strobe cycle, when the output register is cleared or replaced.

## Test plan
- Single write:
  - Stimulus: ALU request rd=5, data=0xDEADBEEF, tag=0x10, one cycle.
  - Response: wb_rd_wr_en high 2 cycles later with addr=5, data=0xDEADBEEF, tag=0x10, src=0.
  - wb_pending[5] is high for 2 cycles, then 0.
- Collision:
  - Stimulus: all four requesters valid in one cycle with rd=1,2,3,4 after reset (rr_ptr=0).
  - Response: four consecutive strobes with src 0,1,2,3 and addr 1,2,3,4; rr_ptr ends at 0.
- Fairness:
  - Stimulus: requesters 0 and 3 valid every cycle.
  - Response: wb_src alternates 0,3,0,3…; neither requester is starved.
- Back-pressure:
  - Stimulus: wb_stall=1; MUL valid every cycle.
  - Response: exactly DEPTH=2 accepts, then req_ready[1]=0 and no strobes.
  - Releasing the stall gives 2 in-order MUL writes, and ready returns.
- x0 drop:
  - Stimulus: LSU request rd=0, data=0x1234.
  - Response: accepted (ready=1); no strobe; wb_pending stays 0.
- Reset mid-operation:
  - Stimulus: 3 entries queued, rst pulsed for one cycle.
  - Response: outputs at reset values immediately; no write strobe after release; req_ready all 1.
